alu_mdu_seq: RTL and testbench

- Multi-cycle controller that sequences the shared 32-bit ALU to perform unsigned multiply (shift-add) and unsigned divide (restoring) for MULTU/DIVU.
- Sits beside the datapath ALU. While busy, it owns the ALU operand and ALUctr inputs through the datapath mux.
- Results land in HI/LO registers held inside this block.
- One iteration per clock, fixed latency.

---
 rtl/alu_mdu_seq_pkg.sv | 23 ++
 rtl/alu_mdu_seq_if.sv | 33 +++
 rtl/alu_mdu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_seq_pkg.sv
// alu_mdu_seq_pkg
//   Shared definitions for the multi-cycle MULTU/DIVU sequencer:
//   - ALUctr codes understood by the shared datapath ALU
//   - sequencer state encoding
//   - op encoding on the request side
package alu_mdu_seq_pkg;

    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b110;
    localparam logic [2:0] ALU_OR     = 3'b001;
    localparam logic [2:0] ALU_PASS_A = 3'b101;
    localparam logic [2:0] ALU_PASS_B = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/alu_mdu_seq_if.sv
// alu_mdu_seq_if
//   Bundles the request/result side (start, op, src_a, src_b, busy, done,
//   hi, lo) and the shared-ALU side (alu_a, alu_b, alu_ctr, alu_result) of
//   the MULTU/DIVU sequencer.
//   master : the requester / datapath (drives the request and the ALU result)
//   slave  : the sequencer itself
interface alu_mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctr;
    logic [WIDTH-1:0] alu_result;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, alu_result,
        input  alu_a, alu_b, alu_ctr, busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, alu_result,
        output alu_a, alu_b, alu_ctr, busy, done, hi, lo
    );

endinterface

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq
//   Sequences the shared datapath ALU to perform unsigned shift-add multiply
//   (MULTU) and unsigned restoring divide (DIVU), one iteration per clock.
//   Results are kept in the HI/LO registers of this block.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : synchronous reset, active-low
//     bus   : alu_mdu_seq_if.slave
//             start/op/src_a/src_b in, busy/done/hi/lo out,
//             alu_a/alu_b/alu_ctr out to the ALU, alu_result back in
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; ALU driven with PASS_B and zero operands
//   RUN   | iterating, busy=1, this block owns the ALU
//   DONE  | one-cycle done pulse; hi/lo valid; start accepted here too
module alu_mdu_seq
    import alu_mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mdu_seq_if.slave  bus
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_t           state;
    state_t           state_nxt;
    logic             op_q;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctr;
    logic [WIDTH-1:0] div_r;
    logic             div_top;
    logic             carry;
    logic             borrow;
    logic             accept;
    logic             div_zero;
    logic             last_iter;
    logic             busy;
    logic             done;

    assign accept    = bus.start && (state != ST_RUN);
    assign div_zero  = (bus.op == OP_DIVU) && (bus.src_b == '0);
    assign last_iter = (cnt == CW'(ITER - 1));

    // Partial remainder shifted left by one with the next dividend bit;
    // the bit shifted out of hi forces a subtract regardless of borrow.
    assign div_r   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign div_top = hi_q[WIDTH-1];

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctr = ALU_PASS_B;
        if (state == ST_RUN) begin
            alu_b = breg;
            if (op_q == OP_MULTU) begin
                alu_a   = hi_q;
                alu_ctr = ALU_ADD;
            end else begin
                alu_a   = div_r;
                alu_ctr = ALU_SUB;
            end
        end
    end

    // The ALU sign-extends, so its own carry flag is not the unsigned carry;
    // both are recovered from unsigned magnitude compares instead.
    assign carry  = (bus.alu_result < alu_a);
    assign borrow = (alu_a < alu_b);

    always_comb begin
        hi_nxt = hi_q;
        lo_nxt = lo_q;
        if (op_q == OP_MULTU) begin
            if (lo_q[0]) begin
                {hi_nxt, lo_nxt} = {carry, bus.alu_result, lo_q[WIDTH-1:1]};
            end else begin
                {hi_nxt, lo_nxt} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end else begin
            if (div_top || !borrow) begin
                hi_nxt = bus.alu_result;
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = div_r;
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    state_nxt = div_zero ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_MULTU;
            breg  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= bus.op;
                breg <= bus.src_b;
                cnt  <= '0;
                if (div_zero) begin
                    hi_q <= bus.src_a;
                    lo_q <= '1;
                end else begin
                    hi_q <= '0;
                    lo_q <= bus.src_a;
                end
            end else if (state == ST_RUN) begin
                cnt  <= cnt + CW'(1);
                hi_q <= hi_nxt;
                lo_q <= lo_nxt;
            end
        end
    end

    assign bus.alu_a   = alu_a;
    assign bus.alu_b   = alu_b;
    assign bus.alu_ctr = alu_ctr;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq
//   Drives alu_mdu_seq through the shared interface with a behavioural ALU
//   attached, and compares hi/lo, latency and ALU control against plain
//   arithmetic (a*b, a/b, a%b).
module tb_alu_mdu_seq;
    import alu_mdu_seq_pkg::*;

    localparam int W  = 32;
    localparam int IT = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_mdu_seq_if #(.WIDTH(W)) bus ();

    alu_mdu_seq #(.WIDTH(W), .ITER(IT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared datapath ALU
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_ctr)
            ALU_ADD:    bus.alu_result = bus.alu_a + bus.alu_b;
            ALU_SUB:    bus.alu_result = bus.alu_a - bus.alu_b;
            ALU_OR:     bus.alu_result = bus.alu_a | bus.alu_b;
            ALU_PASS_A: bus.alu_result = bus.alu_a;
            ALU_PASS_B: bus.alu_result = bus.alu_b;
            default:    bus.alu_result = '0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic void ref_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] h, output logic [W-1:0] l);
        logic [2*W-1:0] p;
        if (o == OP_MULTU) begin
            p = 64'(a) * 64'(b);
            h = p[2*W-1:W];
            l = p[W-1:0];
        end else if (b == '0) begin
            h = a;
            l = '1;
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    // Issues one operation and follows it to its done cycle.
    // inj : cycle number at which a stray start is pulsed (0 = none)
    // b2b : caller is sitting in the previous op's done cycle; start now
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input string nm, input int inj, input bit b2b);
        int          cyc;
        int          busy_n;
        int          ctr_bad;
        int          exp_lat;
        logic [2:0]  exp_ctr;
        bit          dz;
        dz      = (o == OP_DIVU) && (b == '0);
        exp_lat = dz ? 1 : IT + 1;
        exp_ctr = (o == OP_MULTU) ? ALU_ADD : ALU_SUB;
        if (!b2b) begin
            @(negedge clk);
        end
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        cyc     = 1;
        busy_n  = 0;
        ctr_bad = 0;
        while (bus.done !== 1'b1 && cyc <= 200) begin
            if (bus.busy === 1'b1) begin
                busy_n++;
                if (bus.alu_ctr !== exp_ctr) ctr_bad++;
            end
            if (cyc == inj) begin
                bus.start = 1'b1;
                bus.op    = ~o;
            end
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({nm, "_busy_cycles"}, 64'(busy_n), dz ? 64'd0 : 64'(IT));
        chk({nm, "_alu_ctr"}, 64'(ctr_bad), 64'd0);
        chk({nm, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({nm, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, "_lo"}, 64'(bus.lo), 64'(el));
    endtask

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        nm;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [W-1:0] ra, rb, mh, ml;
        logic         ro;

        tbl[0] = '{OP_MULTU, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A, "mul_7x6"};
        tbl[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "mul_max"};
        tbl[2] = '{OP_DIVU,  32'd100,        32'd7,          32'd2,         32'd14,        "div_100_7"};
        tbl[3] = '{OP_DIVU,  32'h8000_0000, 32'd3,          32'd2,         32'h2AAA_AAAA, "div_top"};
        tbl[4] = '{OP_DIVU,  32'd5,          32'd0,          32'd5,         32'hFFFF_FFFF, "div_zero"};
        tbl[5] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "mul_2p16"};

        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.src_a = '0;
        bus.src_b = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_alu_ctr", 64'(bus.alu_ctr), 64'(ALU_PASS_B));
        chk("rst_alu_ab", {32'(bus.alu_a), 32'(bus.alu_b)}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].nm, 0, 1'b0);
        end

        // stray start in the middle of a MULTU must be ignored
        do_op(OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, "mul_ign_start", 10, 1'b0);

        // back-to-back: next op starts in the done cycle of the previous one
        do_op(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, "b2b_first", 0, 1'b0);
        do_op(OP_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, "b2b_second", 0, 1'b1);
        @(negedge clk);
        chk("b2b_done_drop", 64'(bus.done), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            if (ro == OP_DIVU && $urandom_range(0, 7) == 0) rb = '0;
            ref_model(ro, ra, rb, mh, ml);
            do_op(ro, ra, rb, mh, ml, $sformatf("rand%0d", i), 0, 1'b0);
        end

        // reset in the middle of a DIVU
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        chk("midrst_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_hilo", {32'(bus.hi), 32'(bus.lo)}, 64'd0);
        chk("midrst_alu_ctr", 64'(bus.alu_ctr), 64'(ALU_PASS_B));
        rst_n = 1'b1;
        do_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "after_rst_mul", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
